// File: rtl/axi4_globals_pkg.sv
// rtl/axi4_globals_pkg.sv - shared AXI4 widths, burst/response encodings and write-controller state
package axi4_globals_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_ctrl_state_e;

    // WRAP bursts are only legal for 2, 4, 8 or 16 beats
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi4_addr_gen.sv
// rtl/axi4_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi4_addr_gen
    import axi4_globals_pkg::*;
#(
    parameter int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH
) (
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [2:0]               size,
    input  logic [7:0]               len,
    input  logic [1:0]               burst,
    output logic [ADDRESS_WIDTH-1:0] next_addr
);

    logic [ADDRESS_WIDTH-1:0] step;
    logic [ADDRESS_WIDTH-1:0] container;
    logic [ADDRESS_WIDTH-1:0] wrap_mask;
    logic [ADDRESS_WIDTH-1:0] incr_addr;

    assign step      = ADDRESS_WIDTH'(1) << size;
    assign container = (ADDRESS_WIDTH'(len) + ADDRESS_WIDTH'(1)) << size;
    assign wrap_mask = container - ADDRESS_WIDTH'(1);
    assign incr_addr = addr + step;

    always_comb begin
        next_addr = addr;
        case (burst)
            FIXED:   next_addr = addr;
            INCR:    next_addr = incr_addr;
            WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = addr;
        endcase
    end

endmodule

// File: rtl/axi4_slave_wr_ctrl.sv
// rtl/axi4_slave_wr_ctrl.sv - single-outstanding AXI4 slave write path driving a one-port memory
module axi4_slave_wr_ctrl
    import axi4_globals_pkg::*;
#(
    parameter int ADDRESS_WIDTH = axi4_globals_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = axi4_globals_pkg::DATA_WIDTH
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [7:0]                awid,
    input  logic [ADDRESS_WIDTH-1:0]  awaddr,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [7:0]                bid,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    output logic                      mem_we,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int MAX_SIZE   = $clog2(STRB_WIDTH);

    wr_ctrl_state_e state_q, state_d;

    logic                     live_q, live_d;
    logic [7:0]               id_q, id_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               len_q, len_d;
    logic [2:0]               size_q, size_d;
    logic [1:0]               burst_q, burst_d;
    logic [7:0]               cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [STRB_WIDTH-1:0]    mem_wstrb_q, mem_wstrb_d;

    logic [ADDRESS_WIDTH-1:0] next_addr;
    logic                     aw_hs, w_hs, b_hs;
    logic                     len_match, last_beat, aw_err;

    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign b_hs      = bvalid & bready;
    assign len_match = (cnt_q == len_q);
    assign last_beat = wlast | len_match;

    always_comb begin
        aw_err = 1'b0;
        if (awburst == 2'b11) begin
            aw_err = 1'b1;
        end
        if (int'(awsize) > MAX_SIZE) begin
            aw_err = 1'b1;
        end
        if ((awburst == WRAP) && !wrap_len_ok(awlen)) begin
            aw_err = 1'b1;
        end
    end

    axi4_addr_gen #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_addr_gen (
        .addr     (addr_q),
        .size     (size_q),
        .len      (len_q),
        .burst    (burst_q),
        .next_addr(next_addr)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (aw_hs)             state_d = DATA;
            DATA: if (w_hs && last_beat) state_d = RESP;
            RESP: if (b_hs)              state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // live_q holds awready low for the cycle in which reset is released
    always_comb begin
        awready = live_q && (state_q == IDLE);
        wready  = (state_q == DATA);
        bvalid  = (state_q == RESP);
        bresp   = ((state_q == RESP) && err_q) ? SLVERR : OKAY;
    end

    assign bid       = id_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    always_comb begin
        live_d      = 1'b1;
        id_d        = id_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        if (aw_hs) begin
            id_d    = awid;
            addr_d  = awaddr;
            len_d   = awlen;
            size_d  = awsize;
            burst_d = awburst;
            cnt_d   = 8'd0;
            err_d   = aw_err;
        end

        if (w_hs) begin
            cnt_d       = cnt_q + 8'd1;
            addr_d      = next_addr;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q;
            mem_wdata_d = wdata;
            mem_wstrb_d = err_q ? '0 : wstrb;
            // wlast and the count can only disagree on the beat that ends the burst
            if (wlast != len_match) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            live_q      <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            live_q      <= live_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

endmodule

// File: tb/tb_axi4_slave_wr_ctrl.sv
// tb/tb_axi4_slave_wr_ctrl.sv - scoreboard bench for the AXI4 slave write controller
module tb_axi4_slave_wr_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [7:0]    awid;
    logic [AW-1:0] awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic          wlast;
    logic          wvalid;
    logic          wready;
    logic [7:0]    bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;

    always #5 aclk = ~aclk;

    axi4_slave_wr_ctrl #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .awid     (awid),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .awsize   (awsize),
        .awburst  (awburst),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .bid      (bid),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } wr_t;

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } b_t;

    wr_t wr_q[$];
    b_t  b_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] model_next(input logic [AW-1:0] a, input logic [2:0] size,
                                                  input logic [7:0] len, input logic [1:0] burst);
        logic [AW-1:0] step, cont;
        step = AW'(1) << size;
        cont = (AW'(len) + AW'(1)) * step;
        case (burst)
            2'd1:    return a + step;
            2'd2:    return (a & ~(cont - 1)) | ((a + step) & (cont - 1));
            default: return a;
        endcase
    endfunction

    initial begin
        wr_t e;
        b_t  be;
        forever begin
            @(negedge aclk);
            if (mem_we === 1'b1) begin
                if (wr_q.size() == 0) begin
                    check("mem_we_unexpected", 64'(mem_we), 64'd0);
                end else begin
                    e = wr_q.pop_front();
                    check("mem_addr", 64'(mem_addr), 64'(e.addr));
                    check("mem_wdata", 64'(mem_wdata), 64'(e.data));
                    check("mem_wstrb", 64'(mem_wstrb), 64'(e.strb));
                end
            end
            if (bvalid === 1'b1 && bready === 1'b1) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 64'(bvalid), 64'd0);
                end else begin
                    be = b_q.pop_front();
                    check("bid", 64'(bid), 64'(be.id));
                    check("bresp", 64'(bresp), 64'(be.resp));
                end
            end
        end
    end

    // All driver tasks enter and leave 1ns after a rising edge
    task automatic aw_send(input logic [7:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        if (!awready) check("aw_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input int gap, input logic [DW-1:0] d, input logic [SW-1:0] s, input logic last);
        int t;
        repeat (gap) begin @(posedge aclk); #1; end
        wvalid = 1'b1; wdata = d; wstrb = s; wlast = last;
        t = 0;
        @(negedge aclk);
        while (!wready && t < 50) begin @(negedge aclk); t++; end
        if (!wready) check("w_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(input int delay);
        int t;
        repeat (delay) begin @(posedge aclk); #1; end
        bready = 1'b1;
        t = 0;
        @(negedge aclk);
        while (!bvalid && t < 50) begin @(negedge aclk); t++; end
        if (!bvalid) check("b_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic run_burst(input logic [7:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int wlast_at,
                             input int gap_lo, input int gap_hi, input int bdelay, input bit hold);
        int            n;
        logic          lerr, err, last;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        wr_t           e;
        b_t            be;
        lerr = (burst == 2'd3) || (size > 3'd2) ||
               (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        n = (wlast_at > 0 && wlast_at <= int'(len) + 1) ? wlast_at : int'(len) + 1;
        aw_send(id, addr, len, size, burst);
        check("wready_after_aw", 64'(wready), 64'd1);
        check("awready_after_aw", 64'(awready), 64'd0);
        a = addr;
        for (int i = 1; i <= n; i++) begin
            d = $urandom;
            s = SW'($urandom);
            last = (i == wlast_at);
            e.addr = a; e.data = d; e.strb = lerr ? '0 : s;
            wr_q.push_back(e);
            w_beat(int'($urandom_range(gap_hi, gap_lo)), d, s, last);
            a = model_next(a, size, len, burst);
        end
        err = lerr || ((n == wlast_at) != (n == int'(len) + 1));
        be.id = id; be.resp = err ? 2'b10 : 2'b00;
        b_q.push_back(be);
        check("bvalid_after_last", 64'(bvalid), 64'd1);
        check("wready_after_last", 64'(wready), 64'd0);
        check("mem_we_after_last", 64'(mem_we), 64'd1);
        if (hold) begin
            awvalid = 1'b1; awid = ~id; awaddr = 32'h0; awlen = 8'd0; awsize = 3'd2; awburst = 2'd1;
            for (int k = 0; k < 5; k++) begin
                @(negedge aclk);
                check("hold_bvalid", 64'(bvalid), 64'd1);
                check("hold_bid", 64'(bid), 64'(id));
                check("hold_bresp", 64'(bresp), 64'(be.resp));
                check("hold_awready", 64'(awready), 64'd0);
            end
            @(posedge aclk); #1;
            awvalid = 1'b0;
        end
        b_recv(bdelay);
        check("awready_after_b", 64'(awready), 64'd1);
        check("bvalid_after_b", 64'(bvalid), 64'd0);
    endtask

    initial begin
        logic [7:0]    len;
        logic [1:0]    burst;
        logic [2:0]    size;
        int            wl;
        logic [DW-1:0] d;
        logic [7:0]    lens[6];
        lens = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15};

        aresetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; wlast = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge aclk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_bid_bresp", 64'({bid, bresp}), 64'd0);
        check("rst_mem_bus", 64'({mem_addr, mem_wstrb}), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;
        check("awready_after_reset", 64'(awready), 64'd1);

        run_burst(8'h5A, 32'h100, 8'd3, 3'd2, 2'd1, 4, 0, 0, 0, 1'b0);
        run_burst(8'h11, 32'h38, 8'd3, 3'd2, 2'd2, 4, 0, 1, 1, 1'b0);
        run_burst(8'h22, 32'h20, 8'd2, 3'd2, 2'd0, 3, 2, 2, 0, 1'b0);
        run_burst(8'h33, 32'h200, 8'd3, 3'd2, 2'd1, 2, 0, 0, 0, 1'b0);
        run_burst(8'h44, 32'h300, 8'd1, 3'd2, 2'd1, 0, 0, 0, 2, 1'b0);
        run_burst(8'h55, 32'h80, 8'd0, 3'd2, 2'd3, 1, 0, 0, 0, 1'b0);
        run_burst(8'h77, 32'h400, 8'd1, 3'd2, 2'd1, 1, 0, 0, 0, 1'b1);

        wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = '1; wlast = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            check("wready_in_idle", 64'(wready), 64'd0);
        end
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;

        aw_send(8'h66, 32'h500, 8'd3, 3'd2, 2'd1);
        d = $urandom;
        w_beat(0, d, '1, 1'b0);
        aresetn = 1'b0;
        @(negedge aclk);
        check("midrst_mem_we", 64'(mem_we), 64'd0);
        check("midrst_ready_valid", 64'({awready, wready, bvalid}), 64'd0);
        check("midrst_mem_bus", 64'({mem_addr, mem_wstrb}), 64'd0);
        check("midrst_bid", 64'(bid), 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (2) begin
            @(posedge aclk); #1;
            check("midrst_no_bvalid", 64'(bvalid), 64'd0);
        end
        run_burst(8'h99, 32'h600, 8'd3, 3'd2, 2'd1, 4, 0, 0, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            burst = 2'($urandom_range(2, 0));
            size  = 3'($urandom_range(3, 0));
            len   = lens[$urandom_range(5, 0)];
            wl    = int'($urandom_range(int'(len) + 2, 1));
            if ($urandom_range(1, 0) == 1) wl = int'(len) + 1;
            run_burst(8'($urandom), $urandom, len, size, burst, wl, 0, 2, int'($urandom_range(3, 0)), 1'b0);
        end

        repeat (3) @(negedge aclk);
        check("wr_queue_empty", 64'(wr_q.size()), 64'd0);
        check("b_queue_empty", 64'(b_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
